// File: rtl/subsystem_eq1_pipe_if.sv
// rtl/subsystem_eq1_pipe_if.sv - handshake and operand/result bundle for the equation-1 pipeline
interface subsystem_eq1_pipe_if #(
    parameter int N   = 20,
    parameter int IDW = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [IDW-1:0]   in_id;
    logic [N-1:0]     I1;
    logic [N-1:0]     I2;
    logic [N-1:0]     I3;
    logic             out_valid;
    logic             out_ready;
    logic [IDW-1:0]   out_id;
    logic [N-1:0]     O_raw;
    logic [2*N-1:0]   O_full;
    logic             ovf;

    modport master (
        output in_valid, in_id, I1, I2, I3, out_ready,
        input  in_ready, out_valid, out_id, O_raw, O_full, ovf
    );

    modport slave (
        input  in_valid, in_id, I1, I2, I3, out_ready,
        output in_ready, out_valid, out_id, O_raw, O_full, ovf
    );
endinterface

// File: rtl/subsystem_eq1_pipe.sv
// rtl/subsystem_eq1_pipe.sv - 3-stage global-stall pipeline for O = I3*I3*(1-I1) + I2*I1 in Q(N,FRAC)
module subsystem_eq1_pipe #(
    parameter int N    = 20,
    parameter int FRAC = 10,
    parameter int IDW  = 4,
    parameter int SAT  = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    subsystem_eq1_pipe_if.slave   bus
);
    localparam int W = 2 * N;
    localparam logic signed [N-1:0] ONE = N'(1) <<< FRAC;

    function automatic logic signed [W-1:0] fxp_mul(input logic signed [N-1:0] a,
                                                     input logic signed [N-1:0] b);
        return W'(a) * W'(b);
    endfunction

    function automatic logic signed [N-1:0] fxp_sub(input logic signed [N-1:0] a,
                                                    input logic signed [N-1:0] b);
        return a - b;
    endfunction

    function automatic logic signed [W:0] fxp_add(input logic signed [W-1:0] a,
                                                  input logic signed [W-1:0] b);
        return (W+1)'(a) + (W+1)'(b);
    endfunction

    logic signed [N-1:0] i1, i2, i3;
    logic                en;

    logic                s1_valid;
    logic [IDW-1:0]      s1_id;
    logic signed [N-1:0] s1_t0, s1_t1;
    logic signed [W-1:0] s1_pb;

    logic                s2_valid;
    logic [IDW-1:0]      s2_id;
    logic signed [W-1:0] s2_pa, s2_pb;

    logic                s3_valid;
    logic [IDW-1:0]      s3_id;
    logic [N-1:0]        s3_raw;
    logic [W-1:0]        s3_full;
    logic                s3_ovf;

    logic signed [W-1:0] sq;
    logic signed [N-1:0] t0_n, t1_n;
    logic signed [W-1:0] pb_n, pa_n;
    logic signed [W:0]   sum_n, sh_n;
    logic                ovf_n;
    logic [N-1:0]        raw_n;

    assign i1 = $signed(bus.I1);
    assign i2 = $signed(bus.I2);
    assign i3 = $signed(bus.I3);

    // Every stage advances together; a held result freezes the whole pipe.
    assign en           = ~s3_valid | bus.out_ready;
    assign bus.in_ready = en;

    always_comb begin
        sq    = fxp_mul(i3, i3);
        t0_n  = N'(sq >>> FRAC);
        t1_n  = fxp_sub(ONE, i1);
        pb_n  = fxp_mul(i2, i1);
        pa_n  = fxp_mul(s1_t0, s1_t1);
        sum_n = fxp_add(s2_pa, s2_pb);
        sh_n  = sum_n >>> FRAC;
    end

    // The shifted sum fits in N bits only when bits W..N-1 are all sign copies.
    always_comb begin
        ovf_n = (sh_n[W:N-1] != '0) && (sh_n[W:N-1] != '1);
        raw_n = sh_n[N-1:0];
        if ((SAT != 0) && ovf_n) begin
            raw_n = sh_n[W] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_id    <= '0;
            s1_t0    <= '0;
            s1_t1    <= '0;
            s1_pb    <= '0;
            s2_valid <= 1'b0;
            s2_id    <= '0;
            s2_pa    <= '0;
            s2_pb    <= '0;
            s3_valid <= 1'b0;
            s3_id    <= '0;
            s3_raw   <= '0;
            s3_full  <= '0;
            s3_ovf   <= 1'b0;
        end else if (en) begin
            s1_valid <= bus.in_valid;
            s1_id    <= bus.in_id;
            s1_t0    <= t0_n;
            s1_t1    <= t1_n;
            s1_pb    <= pb_n;
            s2_valid <= s1_valid;
            s2_id    <= s1_id;
            s2_pa    <= pa_n;
            s2_pb    <= s1_pb;
            s3_valid <= s2_valid;
            s3_id    <= s2_id;
            s3_raw   <= raw_n;
            s3_full  <= sum_n[W-1:0];
            s3_ovf   <= ovf_n;
        end
    end

    assign bus.out_valid = s3_valid;
    assign bus.out_id    = s3_id;
    assign bus.O_raw     = s3_raw;
    assign bus.O_full    = s3_full;
    assign bus.ovf       = s3_ovf;
endmodule

// File: tb/tb_subsystem_eq1_pipe.sv
// tb/tb_subsystem_eq1_pipe.sv - directed self-checking bench for subsystem_eq1_pipe in both SAT modes
module tb_subsystem_eq1_pipe;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    subsystem_eq1_pipe_if #(.N(20), .IDW(4)) if0 ();
    subsystem_eq1_pipe_if #(.N(20), .IDW(4)) if1 ();

    subsystem_eq1_pipe #(.N(20), .FRAC(10), .IDW(4), .SAT(0)) dut0 (.clk(clk), .rst(rst), .bus(if0));
    subsystem_eq1_pipe #(.N(20), .FRAC(10), .IDW(4), .SAT(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));

    typedef struct {
        logic [3:0]  id;
        logic [19:0] raw0;
        logic [19:0] raw1;
        logic [39:0] full;
        logic        ovf;
    } exp_t;

    exp_t q[$];
    bit   mon_en    = 1'b0;
    int   delivered = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input int a1, input int a2, input int a3, input logic [3:0] id);
        exp_t e;
        longint sq, pa, pb, sum, sh;
        logic signed [19:0] t0, t1;
        sq  = longint'(a3) * longint'(a3);
        t0  = 20'(sq >>> 10);
        t1  = 20'(1024 - a1);
        pa  = longint'(t0) * longint'(t1);
        pb  = longint'(a2) * longint'(a1);
        sum = pa + pb;
        sh  = sum >>> 10;
        e.id   = id;
        e.ovf  = (sh < -524288) || (sh > 524287);
        e.raw0 = sh[19:0];
        e.raw1 = e.ovf ? ((sh < 0) ? 20'h80000 : 20'h7FFFF) : sh[19:0];
        e.full = sum[39:0];
        return e;
    endfunction

    task automatic drive(input logic v, input logic [3:0] id, input int a1, input int a2, input int a3);
        if0.in_valid = v;    if1.in_valid = v;
        if0.in_id    = id;   if1.in_id    = id;
        if0.I1 = 20'(a1);    if1.I1 = 20'(a1);
        if0.I2 = 20'(a2);    if1.I2 = 20'(a2);
        if0.I3 = 20'(a3);    if1.I3 = 20'(a3);
    endtask

    task automatic set_ready(input logic r);
        if0.out_ready = r;
        if1.out_ready = r;
    endtask

    task automatic check_outputs(input string tag, input exp_t e);
        check_val({tag, "_valid0"}, 64'(if0.out_valid), 64'(1));
        check_val({tag, "_valid1"}, 64'(if1.out_valid), 64'(1));
        check_val({tag, "_raw0"},   64'(if0.O_raw),     64'(e.raw0));
        check_val({tag, "_raw1"},   64'(if1.O_raw),     64'(e.raw1));
        check_val({tag, "_full0"},  64'(if0.O_full),    64'(e.full));
        check_val({tag, "_full1"},  64'(if1.O_full),    64'(e.full));
        check_val({tag, "_ovf0"},   64'(if0.ovf),       64'(e.ovf));
        check_val({tag, "_ovf1"},   64'(if1.ovf),       64'(e.ovf));
        check_val({tag, "_id0"},    64'(if0.out_id),    64'(e.id));
        check_val({tag, "_id1"},    64'(if1.out_id),    64'(e.id));
    endtask

    task automatic check_zero(input string tag);
        check_val({tag, "_valid"}, 64'({if0.out_valid, if1.out_valid}), 64'(0));
        check_val({tag, "_raw"},   64'({if0.O_raw, if1.O_raw}),         64'(0));
        check_val({tag, "_full"},  64'({if0.O_full, if1.O_full}),       64'(0));
        check_val({tag, "_ovf"},   64'({if0.ovf, if1.ovf}),             64'(0));
        check_val({tag, "_id"},    64'({if0.out_id, if1.out_id}),       64'(0));
        check_val({tag, "_inrdy"}, 64'({if0.in_ready, if1.in_ready}),   64'(3));
    endtask

    // One sample driven just after an edge is accepted on the next edge and
    // must be presented after the third edge from when it was driven.
    task automatic run_one(input string tag, input int a1, input int a2, input int a3, input exp_t e);
        drive(1'b1, e.id, a1, a2, a3);
        @(posedge clk); #1;
        drive(1'b0, 4'd0, 0, 0, 0);
        @(posedge clk); #1;
        check_val({tag, "_early"}, 64'({if0.out_valid, if1.out_valid}), 64'(0));
        @(posedge clk); #1;
        check_outputs(tag, e);
    endtask

    function automatic exp_t hand(input logic [3:0] id, input logic [19:0] r0, input logic [19:0] r1,
                                  input logic [39:0] f, input logic o);
        exp_t e;
        e.id = id; e.raw0 = r0; e.raw1 = r1; e.full = f; e.ovf = o;
        return e;
    endfunction

    function automatic int op1(input int k); return k * 157 - 700;  endfunction
    function automatic int op2(input int k); return 900 - k * 211;  endfunction
    function automatic int op3(input int k); return k * 333 - 1400; endfunction

    // Scoreboard side of the stream: every presented result is checked each
    // cycle (so a stalled result must stay equal to the head), popped on accept.
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            check_val("bp_inready", 64'({if0.in_ready, if1.in_ready}),
                      {62'd0, {2{~(if0.out_valid & ~if0.out_ready)}}});
            if (if0.out_valid || if1.out_valid) begin
                check_val("bp_sb_nonempty", 64'(q.size() != 0), 64'(1));
                if (q.size() != 0) begin
                    check_outputs("bp", q[0]);
                    if (if0.out_ready) begin
                        void'(q.pop_front());
                        delivered++;
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int   next;
        drive(1'b0, 4'd0, 0, 0, 0);
        set_ready(1'b0);
        @(posedge clk); @(posedge clk); #1;
        check_zero("reset");
        rst = 1'b0;
        set_ready(1'b1);
        @(posedge clk); #1;

        run_one("basic",   512,   2048,   3072,
                hand(4'd3, 20'h01600, 20'h01600, 40'h0000580000, 1'b0));
        run_one("signed",  -1024, 1024,   512,
                hand(4'd5, 20'hFFE00, 20'hFFE00, 40'hFFFFF80000, 1'b0));
        run_one("pos_ovf", -1024, 0,      20480,
                hand(4'd9, 20'hC8000, 20'h7FFFF, 40'h0032000000, 1'b1));
        run_one("neg_ovf", -2048, 523264, 0,
                hand(4'd12, 20'h00800, 20'h80000, 40'hFFC0200000, 1'b1));
        @(posedge clk); #1;

        // Backpressure: continuous stream of ids 0..9, out_ready low for 5 cycles.
        mon_en = 1'b1;
        next   = 0;
        for (int c = 0; c < 60 && next < 10; c++) begin
            set_ready(!(c >= 4 && c < 9));
            drive(1'b1, 4'(next), op1(next), op2(next), op3(next));
            @(negedge clk);
            if (if0.in_ready) begin
                q.push_back(model(op1(next), op2(next), op3(next), 4'(next)));
                next++;
            end
            @(posedge clk); #1;
        end
        check_val("bp_accepted", 64'(next), 64'(10));
        drive(1'b0, 4'd0, 0, 0, 0);
        set_ready(1'b1);
        for (int c = 0; c < 20 && q.size() != 0; c++) begin
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        mon_en = 1'b0;
        check_val("bp_drained",   64'(q.size()),  64'(0));
        check_val("bp_delivered", 64'(delivered), 64'(10));

        // Reset with three samples in flight.
        for (int k = 1; k <= 3; k++) begin
            drive(1'b1, 4'(k), op1(k), op2(k), op3(k));
            @(posedge clk); #1;
        end
        drive(1'b0, 4'd0, 0, 0, 0);
        #2;
        check_val("pre_rst_valid", 64'({if0.out_valid, if1.out_valid}), 64'(3));
        rst = 1'b1;
        #1;
        check_zero("midrst");
        @(posedge clk); #1;
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            check_val("no_stale", 64'({if0.out_valid, if1.out_valid}), 64'(0));
        end
        e = model(op1(7), op2(7), op3(7), 4'd7);
        run_one("post_rst", op1(7), op2(7), op3(7), e);
        @(posedge clk); #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/subsystem_eq1_pipe.md
# subsystem_eq1_pipe

Pipelined, handshaked, parametrised evaluator of O = I3·I3·(1−I1) + I2·I1 in signed fixed point Q(N,FRAC), built from fxp_mul, fxp_sub and fxp_add. It is the registered successor to the combinational equation-1 block in the KF datapath. It adds a 3-stage pipeline with valid/ready backpressure, a transaction tag that passes through with the data, a selectable saturate-or-wrap output policy, and an overflow flag. It accepts one sample per cycle and sits between the KF state registers and the update stage.

## Interface
- N, 20, word width of I1/I2/I3/O_raw (signed, two's complement)
- FRAC, 10, fractional bits; ONE = 1 <<< FRAC
- IDW, 4, width of the pass-through tag
- SAT, 0, 0 = wrap final result to N bits; 1 = clamp to [−2^(N−1), 2^(N−1)−1]
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  input sample present
- in_ready  out  1  block can accept this cycle
- in_id  in  IDW  tag for the input sample
- I1, I2, I3  in  N each  signed Q(N,FRAC) operands
- out_valid  out  1  result present
- out_ready  in  1  downstream accepts result
- out_id  out  IDW  tag of the result (equals the in_id of the same sample)
- O_raw  out  N  final result after the FRAC shift and the wrap or saturate step
- O_full  out  2N  low 2N bits of the unshifted sum, for debug
- ovf  out  1  final shifted sum did not fit in N bits (asserted in both SAT modes)

## Operation
- The arithmetic is bit-identical to the combinational equation-1 block:
  - S1 computes t0 = low N bits of (I3·I3 >>> FRAC), t1 = low N bits of (ONE − I1), and pB = I2·I1 at full 2N width.
  - S2 computes pA = t0·t1 at full 2N width. pB moves forward unchanged.
  - S3 computes sum = pA + pB at 2N+1 bits (fxp_add #(2N)), then sh = sum >>> FRAC (arithmetic shift).
- Intermediate truncation of t0 and t1 wraps silently and is not flagged.
- ovf = 1 when sh < −2^(N−1) or sh > 2^(N−1)−1.
- O_raw:
  - SAT=0: sh[N−1:0].
  - SAT=1: clamped to 0x7FF…F or 0x80…0 on overflow; otherwise sh[N−1:0].
- O_full = sum[2N−1:0].
- Stage registers hold valid, id and data for each of S1, S2, S3. S3 drives the outputs directly.
- Global-stall pipeline:
  - en = ~out_valid | out_ready, and in_ready = en (combinational).
  - When en = 1, every stage loads from its predecessor. S1 loads in_valid & in_ready together with the input data.
  - When en = 0, all stages hold, so bubbles are not compressed during a stall.
- Result order equals acceptance order. No sample is dropped or duplicated.
- Data registers are updated only when en = 1. Their contents are don't-care while the stage's valid bit is 0, but the bench must not see X on the outputs after reset.

## Timing
- Reset (async assert, sync-safe deassert):
  - out_valid = 0, O_raw = 0, O_full = 0, ovf = 0, out_id = 0.
  - All internal valid bits are 0; all data registers are 0.
  - in_ready = 1 during and after reset.
- Latency: a sample accepted at edge k (in_valid & in_ready high) appears with out_valid = 1 after edge k+3, provided en stays 1.
- Throughput: 1 sample per cycle while out_ready = 1.
- Handshake:
  - Once out_valid = 1, O_raw, O_full, ovf and out_id stay stable until the cycle in which out_ready = 1.
  - in_valid may drop at any time. in_ready may depend on out_ready in the same cycle (combinational path).
- Simultaneous events: with out_valid = 1 and out_ready = 1, the held result is consumed and a new input is accepted in the same cycle.
- Reset mid-operation: every in-flight sample is discarded, and out_valid falls immediately (asynchronously).
- Critical path: one N×N multiply per stage, plus a 2N-bit add and clamp in S3.

## Test plan
All cases use N=20, FRAC=10, so ONE = 1024.
- **Basic:** I1=512, I2=2048, I3=3072, id=3 → three cycles later O_raw=5632 (5.5), O_full=5767168, ovf=0, out_id=3.
- **Signed operands:** I1=−1024, I2=1024, I3=512 → O_raw=−512 (−0.5), ovf=0.
- **Positive overflow:** I1=−1024, I2=0, I3=20480 (sum = 800.0):
  - SAT=1 → O_raw=0x7FFFF, ovf=1.
  - SAT=0 → O_raw=−229376, ovf=1.
- **Negative overflow:** I1=−2048, I2=523264, I3=0 (sum = −1022.0), SAT=1 → O_raw=0x80000, ovf=1.
- **Backpressure:**
  - Stimulus: in_valid high every cycle with ids 0..9; out_ready low for 5 cycles in the middle.
  - Required: in_ready low exactly while out_valid & ~out_ready; the outputs held stable during the stall; all 10 results delivered in id order with none dropped or duplicated; each result matching the reference model.
- **Reset mid-stream:** assert rst with 3 samples in flight → out_valid=0 immediately and all outputs 0. After release, a new sample emerges exactly 3 cycles after acceptance, and no stale sample appears.
